// File: rtl/state_machine_pkg.sv
// Shared types and constants for the button-driven state machine.
// Debounce build option: STATE_MACHINE_DEBOUNCE_EN.
package state_machine_pkg;

  localparam int NUM_STATES  = 5;
  localparam int NUM_BUTTONS = 6;

  localparam int BTN_NEXT   = 0;
  localparam int BTN_PREV   = 1;
  localparam int BTN_HOME   = 2;
  localparam int BTN_END    = 3;
  localparam int BTN_LOCK   = 4;
  localparam int BTN_INVERT = 5;

  typedef enum logic [2:0] {
    ST0 = 3'd0,
    ST1 = 3'd1,
    ST2 = 3'd2,
    ST3 = 3'd3,
    ST4 = 3'd4
  } state_t;

endpackage

// File: rtl/state_machine_if.sv
// Button / led bundle between the panel and the state machine.
// Debounce build option: STATE_MACHINE_DEBOUNCE_EN.
interface state_machine_if;
  import state_machine_pkg::*;

  logic [NUM_BUTTONS-1:0] button;
  logic [NUM_STATES-1:0]  led;

  modport master (output button, input led);
  modport slave  (input button, output led);

endinterface

// File: rtl/state_machine_button_conditioner.sv
// One button: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce build option: STATE_MACHINE_DEBOUNCE_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_,
  input  logic raw,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef STATE_MACHINE_DEBOUNCE_EN
  logic [7:0] cnt;
  logic       deb;

  // Follow sync2 only after it has held a new value long enough.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt <= 8'd0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= 8'd0;
    end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= 8'd0;
      deb <= sync2;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign level = deb;
`else
  assign level = sync2;
`endif

  // Remember last level so a held button pulses only once.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) level_q <= 1'b0;
    else         level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/state_machine.sv
// Five-state selector driven by NEXT/PREV/HOME/END/LOCK/INVERT.
// Debounce build option: STATE_MACHINE_DEBOUNCE_EN.
module state_machine
  import state_machine_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset_,
  state_machine_if.slave bus
);

  logic [NUM_BUTTONS-1:0] pulse;
  state_t                 state;
  state_t                 state_nxt;
  logic                   lock_q;
  logic                   invert_q;
  logic                   mv_next;
  logic                   mv_prev;
  logic                   mv_home;
  logic                   mv_end;
  logic [NUM_STATES-1:0]  onehot;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .reset_(reset_),
      .raw   (bus.button[i]),
      .pulse (pulse[i])
    );
  end

  assign mv_next = pulse[BTN_NEXT] & ~lock_q;
  assign mv_prev = pulse[BTN_PREV] & ~lock_q;
  assign mv_home = pulse[BTN_HOME] & ~lock_q;
  assign mv_end  = pulse[BTN_END]  & ~lock_q;

  // Pick the move; HOME beats END, NEXT+PREV cancel.
  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      mv_home:           state_nxt = ST0;
      mv_end:            state_nxt = ST4;
      mv_next & mv_prev: state_nxt = state;
      mv_next:
        state_nxt = (state == ST4) ? ST0
                  : state_t'(state + 3'd1);
      mv_prev:
        state_nxt = (state == ST0) ? ST4
                  : state_t'(state - 3'd1);
      default:           state_nxt = state;
    endcase
  end

  // State and flags; lock uses its pre-edge value.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= ST0;
      lock_q   <= 1'b0;
      invert_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_q   <= lock_q ^ pulse[BTN_LOCK];
      invert_q <= invert_q ^ pulse[BTN_INVERT];
    end
  end

  // Led decode from registered state only.
  always_comb begin
    onehot  = NUM_STATES'(1) << state;
    bus.led = invert_q ? ~onehot : onehot;
  end

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine.
// Debounce build option: STATE_MACHINE_DEBOUNCE_EN.
module tb_state_machine;

  localparam logic [5:0] B_NEXT = 6'b000001;
  localparam logic [5:0] B_PREV = 6'b000010;
  localparam logic [5:0] B_HOME = 6'b000100;
  localparam logic [5:0] B_END  = 6'b001000;
  localparam logic [5:0] B_LOCK = 6'b010000;
  localparam logic [5:0] B_INV  = 6'b100000;

`ifdef STATE_MACHINE_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic reset_;
  int   checks;
  int   fails;

  state_machine_if bus ();

  state_machine #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic [5:0] m,
                       input int hold,
                       input int rel);
    @(negedge clk);
    bus.button = m;
    repeat (hold) @(negedge clk);
    bus.button = '0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_     = 1'b0;
    bus.button = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.led !== 5'b00001) begin
      fails++;
      $display("FAIL in_reset led=%b exp=00001", bus.led);
    end
    reset_ = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.led !== 5'b00001) begin
      fails++;
      $display("FAIL after_reset led=%b exp=00001", bus.led);
    end
  endtask

  task automatic test_next_wrap();
    logic [4:0] exp_q[5];
    exp_q = '{5'b00010, 5'b00100, 5'b01000,
              5'b10000, 5'b00001};
    for (int i = 0; i < 5; i++) begin
      press(B_NEXT, 8, 8);
      checks++;
      if (bus.led !== exp_q[i]) begin
        fails++;
        $display("FAIL next_%0d led=%b exp=%b",
                 i, bus.led, exp_q[i]);
      end
    end
  endtask

  task automatic test_moves();
    logic [5:0] m_q[10];
    logic [4:0] e_q[10];
    m_q = '{B_PREV, B_HOME, B_END, B_HOME,
            B_NEXT, B_NEXT, B_HOME | B_NEXT,
            B_NEXT | B_PREV, B_HOME | B_END,
            B_END | B_PREV};
    e_q = '{5'b10000, 5'b00001, 5'b10000,
            5'b00001, 5'b00010, 5'b00100,
            5'b00001, 5'b00001, 5'b00001,
            5'b10000};
    for (int i = 0; i < 10; i++) begin
      press(m_q[i], 8, 8);
      checks++;
      if (bus.led !== e_q[i]) begin
        fails++;
        $display("FAIL move_%0d led=%b exp=%b",
                 i, bus.led, e_q[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [5:0] m_q[9];
    logic [4:0] e_q[9];
    m_q = '{B_HOME, B_LOCK, B_NEXT, B_END,
            B_LOCK, B_NEXT, B_LOCK | B_NEXT,
            B_NEXT, B_LOCK | B_NEXT};
    e_q = '{5'b00001, 5'b00001, 5'b00001,
            5'b00001, 5'b00001, 5'b00010,
            5'b00100, 5'b00100, 5'b00100};
    for (int i = 0; i < 9; i++) begin
      press(m_q[i], 8, 8);
      checks++;
      if (bus.led !== e_q[i]) begin
        fails++;
        $display("FAIL lock_%0d led=%b exp=%b",
                 i, bus.led, e_q[i]);
      end
    end
    press(B_NEXT, 8, 8);
    checks++;
    if (bus.led !== 5'b01000) begin
      fails++;
      $display("FAIL lock_unlocked led=%b exp=01000",
               bus.led);
    end
  endtask

  task automatic test_invert();
    logic [5:0] m_q[8];
    logic [4:0] e_q[8];
    m_q = '{B_HOME, B_INV, B_NEXT, B_INV,
            B_LOCK, B_INV, B_INV, B_LOCK};
    e_q = '{5'b00001, 5'b11110, 5'b11101,
            5'b00010, 5'b00010, 5'b11101,
            5'b00010, 5'b00010};
    for (int i = 0; i < 8; i++) begin
      press(m_q[i], 8, 8);
      checks++;
      if (bus.led !== e_q[i]) begin
        fails++;
        $display("FAIL invert_%0d led=%b exp=%b",
                 i, bus.led, e_q[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic [4:0] prev;
    int         edges;
    prev  = bus.led;
    edges = 0;
    @(negedge clk);
    bus.button = B_NEXT;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.led !== prev) begin
        edges = i;
        break;
      end
    end
    checks++;
    if (edges != LAT) begin
      fails++;
      $display("FAIL latency edges=%0d exp=%0d",
               edges, LAT);
    end
    repeat (8) @(negedge clk);
    bus.button = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.led !== 5'b00100) begin
      fails++;
      $display("FAIL latency_led led=%b exp=00100",
               bus.led);
    end
  endtask

  task automatic test_held();
    @(negedge clk);
    bus.button = B_NEXT;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.led !== 5'b01000) begin
      fails++;
      $display("FAIL held_mid led=%b exp=01000",
               bus.led);
    end
    repeat (20) @(negedge clk);
    bus.button = '0;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.led !== 5'b01000) begin
      fails++;
      $display("FAIL held_release led=%b exp=01000",
               bus.led);
    end
  endtask

  task automatic test_async_reset();
    press(B_LOCK | B_INV, 8, 8);
    checks++;
    if (bus.led !== 5'b10111) begin
      fails++;
      $display("FAIL pre_reset led=%b exp=10111",
               bus.led);
    end
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    checks++;
    if (bus.led !== 5'b00001) begin
      fails++;
      $display("FAIL async_reset led=%b exp=00001",
               bus.led);
    end
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    press(B_NEXT, 8, 8);
    checks++;
    if (bus.led !== 5'b00010) begin
      fails++;
      $display("FAIL post_reset led=%b exp=00010",
               bus.led);
    end
  endtask

  task automatic test_reset_held();
    @(negedge clk);
    reset_     = 1'b0;
    bus.button = B_NEXT;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.led !== 5'b00001) begin
      fails++;
      $display("FAIL held_in_reset led=%b exp=00001",
               bus.led);
    end
    reset_ = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (bus.led !== 5'b00010) begin
      fails++;
      $display("FAIL held_thru_reset led=%b exp=00010",
               bus.led);
    end
    bus.button = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.led !== 5'b00010) begin
      fails++;
      $display("FAIL held_thru_rel led=%b exp=00010",
               bus.led);
    end
  endtask

`ifdef STATE_MACHINE_DEBOUNCE_EN
  task automatic test_debounce();
    press(B_NEXT, 2, 12);
    checks++;
    if (bus.led !== 5'b00010) begin
      fails++;
      $display("FAIL glitch led=%b exp=00010",
               bus.led);
    end
    press(B_NEXT, 10, 10);
    checks++;
    if (bus.led !== 5'b00100) begin
      fails++;
      $display("FAIL deb_held led=%b exp=00100",
               bus.led);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    fails      = 0;
    reset_     = 1'b0;
    bus.button = '0;
    test_reset();
    test_next_wrap();
    test_moves();
    test_lock();
    test_invert();
    test_latency();
    test_held();
    test_async_reset();
    test_reset_held();
`ifdef STATE_MACHINE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/state_machine.md
STATE_MACHINE -- requirements
Module: state_machine

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable clocks required before a debounced button changes (range 1..255).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_  input  1  asynchronous, active-low reset.
REQ-004 button  input  6  raw asynchronous push-buttons, active-high; bit 0 NEXT, 1 PREV, 2 HOME, 3 END, 4 LOCK, 5 INVERT.
REQ-005 led  output  5  state indicator, one-hot of current state, optionally inverted.

Function
REQ-006 Each button bit SHALL pass through a 2-flop synchronizer, then optional debounce (REQ-020), then a rising-edge detector producing a one-clock press pulse.
REQ-007 FSM states ST0..ST4; led = 5'b1 << state index when invert flag is 0, bitwise complement of that when invert flag is 1.
REQ-008 led SHALL be a combinational decode of registered state and invert flag only (no combinational path from button).
REQ-009 NEXT press: ST0→ST1→ST2→ST3→ST4→ST0 (wrap-around at ST4).
REQ-010 PREV press: ST4→ST3→…→ST0→ST4 (wrap-around at ST0).
REQ-011 HOME press: go to ST0; END press: go to ST4.
REQ-012 Same-cycle move pulses, priority: HOME > END > (NEXT and PREV together = no move) > NEXT > PREV.
REQ-013 LOCK press toggles lock flag; while lock flag is 1, NEXT/PREV/HOME/END pulses are ignored.
REQ-014 Lock flag value before the current edge governs that edge; a LOCK pulse coincident with a move pulse does not affect that move.
REQ-015 INVERT press toggles invert flag; invert is honoured regardless of lock flag.
REQ-016 A held button produces exactly one pulse; release produces none.
REQ-017 Latency without debounce: led reflects a press after the 3rd rising edge following the button rising (2 sync + 1 state update).

Reset
REQ-018 reset_ low SHALL immediately clear: state=ST0, lock=0, invert=0, all synchronizer, debounce and edge-detect registers=0; led=5'b00001 during and after reset.
REQ-019 A button held through reset release SHALL register as one press once synchronized.

Configuration
REQ-020 Macro STATE_MACHINE_DEBOUNCE_EN: when defined, the debounced level changes only after the synchronized level has differed from it on DEBOUNCE_CYCLES consecutive edges (counter restarts on any bounce); latency becomes 2 + DEBOUNCE_CYCLES + 1 edges; pulses shorter than DEBOUNCE_CYCLES clocks are ignored.
REQ-021 When STATE_MACHINE_DEBOUNCE_EN is undefined, the synchronized level feeds the edge detector directly, no counters are instantiated, and DEBOUNCE_CYCLES is unused.

Structure
REQ-022 Package state_machine_pkg SHALL hold state_t enum (ST0..ST4), NUM_STATES=5, NUM_BUTTONS=6 and button index constants BTN_NEXT, BTN_PREV, BTN_HOME, BTN_END, BTN_LOCK, BTN_INVERT.
REQ-023 Sub-module button_conditioner (synchronizer, optional debounce, edge detect; one bit) SHALL be instantiated NUM_BUTTONS times via generate.
REQ-024 FSM next-state and led decode SHALL reside in state_machine.

Verification
REQ-025 Assert reset_=0 mid-operation at ST3 → led=5'b00001 immediately (asynchronously); lock and invert cleared.
REQ-026 Five NEXT presses (each held 8 clocks, released 8 clocks) from ST0 → led 00010, 00100, 01000, 10000, 00001.
REQ-027 From ST0: PREV → 10000; HOME → 00001; END → 10000; HOME+NEXT same cycle from ST2 → 00001; NEXT+PREV same cycle → unchanged.
REQ-028 LOCK press, then NEXT → led unchanged; LOCK again, NEXT → advances one state.
REQ-029 At ST0 press INVERT → led=5'b11110; NEXT → 5'b11101; INVERT → 5'b00010.
REQ-030 With STATE_MACHINE_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: 2-clock NEXT glitch → no change; NEXT held 10 clocks → exactly one advance, led changes 7 edges after the button rises.
